// File: rtl/sel_pipe_mux_if.sv
// Handshake/data bundle for sel_pipe_mux: select inputs, elastic output, flush and error flag.
// The master side drives the inputs and consumes the outputs; the slave side is the mux block.
interface sel_pipe_mux_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
);
    logic [NUM_IN*WIDTH-1:0] in_bus;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    in_ready;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    out_ready;
    logic                    flush;
    logic                    err_sel;

    modport master (
        output in_bus, sel, in_valid, out_ready, flush,
        input  in_ready, out_data, out_valid, err_sel
    );

    modport slave (
        input  in_bus, sel, in_valid, out_ready, flush,
        output in_ready, out_data, out_valid, err_sel
    );
endinterface

// File: rtl/sel_pipe_mux.sv
// N-way select mux feeding a two-entry elastic output stage (head + skid register).
// Define SEL_PIPE_MUX_ERR_EN to build the sticky out-of-range select flag on err_sel.
module sel_pipe_mux #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 8,
    parameter int SEL_W  = 3
) (
    input logic          clk,
    input logic          rst,
    sel_pipe_mux_if.slave bus
);

    logic [WIDTH-1:0] head_data;
    logic [WIDTH-1:0] skid_data;
    logic [WIDTH-1:0] sel_value;
    logic             head_valid;
    logic             skid_valid;
    logic             push;
    logic             pop;

    // Selects with no matching input fall through to the all-zero default.
    always_comb begin
        sel_value = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if ({1'b0, bus.sel} == (SEL_W+1)'(k)) begin
                sel_value = bus.in_bus[k*WIDTH +: WIDTH];
            end
        end
    end

    // The skid register is only ever occupied while the head is, so skid_valid means "full".
    assign bus.in_ready  = !bus.flush && !skid_valid;
    assign push          = bus.in_valid && bus.in_ready;
    assign pop           = head_valid && bus.out_ready;
    assign bus.out_data  = head_data;
    assign bus.out_valid = head_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_data  <= '0;
            head_valid <= 1'b0;
            skid_data  <= '0;
            skid_valid <= 1'b0;
        end else if (bus.flush) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else if (pop) begin
            if (skid_valid) begin
                head_data  <= skid_data;
                skid_valid <= 1'b0;
            end else if (push) begin
                head_data  <= sel_value;
            end else begin
                head_valid <= 1'b0;
            end
        end else if (push) begin
            if (!head_valid) begin
                head_data  <= sel_value;
                head_valid <= 1'b1;
            end else begin
                skid_data  <= sel_value;
                skid_valid <= 1'b1;
            end
        end
    end

`ifdef SEL_PIPE_MUX_ERR_EN
    localparam logic [SEL_W:0] NUM_IN_W = (SEL_W+1)'(NUM_IN);
    logic err_q;

    // Sticky until reset or flush; the data path still pushes zeros for the bad select.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else if (bus.flush) begin
            err_q <= 1'b0;
        end else if (push && ({1'b0, bus.sel} >= NUM_IN_W)) begin
            err_q <= 1'b1;
        end
    end

    assign bus.err_sel = err_q;
`else
    assign bus.err_sel = 1'b0;
`endif

endmodule

// File: tb/tb_sel_pipe_mux.sv
// Testbench for sel_pipe_mux: an 8-input and a 6-input instance share one stimulus stream
// and are compared against a queue-level reference model plus a directed vector table.
module tb_sel_pipe_mux;

    localparam int WIDTH = 32;
    localparam int SEL_W = 3;
`ifdef SEL_PIPE_MUX_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    sel_pipe_mux_if #(.WIDTH(WIDTH), .NUM_IN(8), .SEL_W(SEL_W)) bus8 ();
    sel_pipe_mux_if #(.WIDTH(WIDTH), .NUM_IN(6), .SEL_W(SEL_W)) bus6 ();

    sel_pipe_mux #(.WIDTH(WIDTH), .NUM_IN(8), .SEL_W(SEL_W)) dut8 (.clk(clk), .rst(rst), .bus(bus8));
    sel_pipe_mux #(.WIDTH(WIDTH), .NUM_IN(6), .SEL_W(SEL_W)) dut6 (.clk(clk), .rst(rst), .bus(bus6));

    typedef struct {
        logic        iv;
        logic [2:0]  sel;
        logic        ordy;
        logic        fl;
        logic        ov;
        logic [31:0] od;
        logic        ir;
    } vec_t;

    vec_t        tbl[$];
    logic [31:0] words[8];
    logic        cur_iv, cur_ordy, cur_fl;
    logic [2:0]  cur_sel;

    logic [31:0] q8[$];
    logic [31:0] q6[$];
    bit          err6_m;

    int vectors;
    int miscompares;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic addRow(input logic iv, input logic [2:0] sel, input logic ordy, input logic fl,
                          input logic ov, input logic [31:0] od, input logic ir);
        vec_t v;
        v.iv = iv; v.sel = sel; v.ordy = ordy; v.fl = fl; v.ov = ov; v.od = od; v.ir = ir;
        tbl.push_back(v);
    endtask

    task automatic applyStimulus(input logic iv, input logic [2:0] sel, input logic ordy, input logic fl);
        cur_iv = iv; cur_sel = sel; cur_ordy = ordy; cur_fl = fl;
        for (int k = 0; k < 8; k++) begin
            bus8.in_bus[k*WIDTH +: WIDTH] = words[k];
            if (k < 6) bus6.in_bus[k*WIDTH +: WIDTH] = words[k];
        end
        bus8.in_valid = iv; bus8.sel = sel; bus8.out_ready = ordy; bus8.flush = fl;
        bus6.in_valid = iv; bus6.sel = sel; bus6.out_ready = ordy; bus6.flush = fl;
    endtask

    // Compare both instances against the reference model for the current cycle.
    task automatic checkOutput(input string tag);
        logic exp_ir;
        exp_ir = !cur_fl && (q8.size() < 2);
        check({tag, ".in_ready8"},  32'(bus8.in_ready),  32'(exp_ir));
        check({tag, ".out_valid8"}, 32'(bus8.out_valid), 32'(q8.size() > 0));
        if (q8.size() > 0) check({tag, ".out_data8"}, bus8.out_data, q8[0]);
        check({tag, ".err8"}, 32'(bus8.err_sel), 32'd0);
        check({tag, ".in_ready6"},  32'(bus6.in_ready),  32'(exp_ir));
        check({tag, ".out_valid6"}, 32'(bus6.out_valid), 32'(q6.size() > 0));
        if (q6.size() > 0) check({tag, ".out_data6"}, bus6.out_data, q6[0]);
        check({tag, ".err6"}, 32'(bus6.err_sel), 32'(err6_m));
    endtask

    task automatic modelStep();
        bit push, pop;
        push = cur_iv && !cur_fl && (q8.size() < 2);
        pop  = (q8.size() > 0) && cur_ordy;
        if (cur_fl) begin
            q8.delete();
            q6.delete();
            err6_m = 1'b0;
        end else begin
            if (pop) begin
                void'(q8.pop_front());
                void'(q6.pop_front());
            end
            if (push) begin
                q8.push_back(words[cur_sel]);
                q6.push_back(cur_sel < 6 ? words[cur_sel] : 32'd0);
                if (cur_sel >= 6 && ERR_EN) err6_m = 1'b1;
            end
        end
    endtask

    task automatic finishCycle(input string tag);
        checkOutput(tag);
        modelStep();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        err6_m = 1'b0;
        for (int k = 0; k < 8; k++) words[k] = 32'h1000_0000 + 32'(k);
        rst = 1'b1;
        applyStimulus(1'b0, 3'd0, 1'b0, 1'b0);

        // Reset state
        @(negedge clk);
        check("rst.out_valid", 32'(bus8.out_valid), 32'd0);
        check("rst.out_data",  bus8.out_data,       32'd0);
        check("rst.in_ready",  32'(bus8.in_ready),  32'd1);
        check("rst.err_sel6",  32'(bus6.err_sel),   32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Directed table: single push, streaming, back-pressure, flush
        addRow(1, 5, 1, 0, 0, 32'h0, 1);
        addRow(0, 0, 1, 0, 1, 32'h1000_0005, 1);
        addRow(0, 0, 1, 0, 0, 32'h0, 1);
        for (int i = 0; i < 16; i++)
            addRow(1, 3'(i % 8), 1, 0, i > 0, (i > 0) ? 32'h1000_0000 + 32'((i - 1) % 8) : 32'h0, 1);
        addRow(0, 0, 1, 0, 1, 32'h1000_0007, 1);
        addRow(0, 0, 1, 0, 0, 32'h0, 1);
        addRow(1, 1, 0, 0, 0, 32'h0, 1);
        addRow(1, 2, 0, 0, 1, 32'h1000_0001, 1);
        addRow(1, 3, 0, 0, 1, 32'h1000_0001, 0);
        addRow(1, 3, 0, 0, 1, 32'h1000_0001, 0);
        addRow(1, 3, 1, 0, 1, 32'h1000_0001, 0);
        addRow(1, 3, 1, 0, 1, 32'h1000_0002, 1);
        addRow(0, 0, 1, 0, 1, 32'h1000_0003, 1);
        addRow(0, 0, 1, 0, 0, 32'h0, 1);
        addRow(1, 4, 0, 0, 0, 32'h0, 1);
        addRow(1, 5, 0, 0, 1, 32'h1000_0004, 1);
        addRow(1, 6, 0, 1, 1, 32'h1000_0004, 0);
        addRow(0, 0, 0, 0, 0, 32'h0, 1);
        addRow(0, 0, 1, 0, 0, 32'h0, 1);

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].iv, tbl[i].sel, tbl[i].ordy, tbl[i].fl);
            @(negedge clk);
            check($sformatf("tbl%0d.out_valid", i), 32'(bus8.out_valid), 32'(tbl[i].ov));
            if (tbl[i].ov) check($sformatf("tbl%0d.out_data", i), bus8.out_data, tbl[i].od);
            check($sformatf("tbl%0d.in_ready", i), 32'(bus8.in_ready), 32'(tbl[i].ir));
            finishCycle($sformatf("tbl%0d", i));
        end

        // Out-of-range select on the 6-input instance
        applyStimulus(1'b1, 3'd7, 1'b1, 1'b0);
        @(negedge clk);
        finishCycle("oob.push");
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("oob.out_valid6", 32'(bus6.out_valid), 32'd1);
        check("oob.out_data6",  bus6.out_data,       32'd0);
        check("oob.out_data8",  bus8.out_data,       32'h1000_0007);
        check("oob.err6",       32'(bus6.err_sel),   32'(ERR_EN));
        finishCycle("oob.pop");
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("oob.err6_sticky", 32'(bus6.err_sel), 32'(ERR_EN));
        finishCycle("oob.idle");
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b1);
        @(negedge clk);
        finishCycle("oob.flush");
        applyStimulus(1'b0, 3'd0, 1'b1, 1'b0);
        @(negedge clk);
        check("oob.err6_cleared", 32'(bus6.err_sel), 32'd0);
        finishCycle("oob.after");

        // Asynchronous reset mid-stream with both entries occupied
        applyStimulus(1'b1, 3'd1, 1'b0, 1'b0);
        @(negedge clk);
        finishCycle("arst.fill0");
        applyStimulus(1'b1, 3'd2, 1'b0, 1'b0);
        @(negedge clk);
        finishCycle("arst.fill1");
        applyStimulus(1'b1, 3'd3, 1'b1, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("arst.out_valid", 32'(bus8.out_valid), 32'd0);
        check("arst.out_data",  bus8.out_data,       32'd0);
        check("arst.in_ready",  32'(bus8.in_ready),  32'd1);
        q8.delete();
        q6.delete();
        err6_m = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            for (int k = 0; k < 8; k++) words[k] = $urandom;
            applyStimulus(1'($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                          1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 19) == 0));
            @(negedge clk);
            finishCycle($sformatf("rnd%0d", c));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
